// File: rtl/seed_loader.sv
// seed_loader: writes one of four seed patterns into the four 4x4 blocks of
// the life board, optionally aligned to the start of a video frame so the
// board never changes mid-scan.
module seed_loader #(
  parameter bit          SYNC_TO_FRAME = 1'b1,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  pattern_sel,
  input  logic        frame,
  output logic        wr_en,
  output logic [1:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    WRITE      = 2'd2,
    DONE       = 2'd3
  } state_t;

  localparam logic [15:0] GLIDER_WORD  = 16'h0742;
  localparam logic [15:0] BLINKER_WORD = 16'h0070;

  state_t      state_q, state_d;
  logic [1:0]  pat_q, pat_d;
  logic [1:0]  addr_q, addr_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] data_q, data_d;
  logic        wr_en_q, busy_q, done_q;
  logic        lfsr_fb;

  // Next-state logic; the pattern is captured only when a start is accepted.
  // frame is not looked at in IDLE, so a pulse coincident with the accepted
  // start is ignored and the load waits for the following frame.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d   = pattern_sel;
          state_d = SYNC_TO_FRAME ? WAIT_FRAME : WRITE;
        end
      end
      WAIT_FRAME: begin
        if (frame) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (addr_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: outputs are precomputed from the next state so that the
  // registered strobe, address and data line up with the WRITE cycles.
  // The LFSR steps only at the end of a pattern-3 write cycle, and the
  // word presented in each write cycle is the LFSR value held during it.
  always_comb begin
    lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d  = lfsr_q;
    if (state_q == WRITE && pat_q == 2'd3) begin
      lfsr_d = {lfsr_q[14:0], lfsr_fb};
    end
    addr_d = 2'd0;
    data_d = 16'h0000;
    if (state_d == WRITE) begin
      addr_d = (state_q == WRITE) ? addr_q + 2'd1 : 2'd0;
      case (pat_d)
        2'd0:    data_d = 16'h0000;
        2'd1:    data_d = (addr_d == 2'd0) ? GLIDER_WORD : 16'h0000;
        2'd2:    data_d = BLINKER_WORD;
        default: data_d = lfsr_d;
      endcase
    end
  end

  // State, latched pattern, LFSR and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= 2'd0;
      lfsr_q  <= LFSR_SEED;
      addr_q  <= 2'd0;
      data_q  <= 16'h0000;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      lfsr_q  <= lfsr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_en_q <= (state_d == WRITE);
      busy_q  <= (state_d == WAIT_FRAME) || (state_d == WRITE);
      done_q  <= (state_d == DONE);
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = addr_q;
  assign wr_data = data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seed_loader.sv
// Bench for seed_loader: one frame-synchronised instance and one immediate
// instance; stimulus pushes expected writes/done pulses into queues and
// per-instance monitors pop and compare them as the DUTs present them.
module tb_seed_loader;

  typedef struct {
    int          cyc;
    logic        is_done;
    logic [1:0]  addr;
    logic [15:0] data;
  } item_t;

  logic clk, rst;
  logic start_a, frame_a, wr_en_a, busy_a, done_a;
  logic [1:0] sel_a, wr_addr_a;
  logic [15:0] wr_data_a;
  logic start_b, frame_b, wr_en_b, busy_b, done_b;
  logic [1:0] sel_b, wr_addr_b;
  logic [15:0] wr_data_b;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  item_t qa[$];
  item_t qb[$];
  logic [15:0] lfsr_a = 16'hACE1;
  logic [15:0] lfsr_b = 16'hACE1;

  seed_loader #(.SYNC_TO_FRAME(1'b1), .LFSR_SEED(16'hACE1)) dut_a (
    .clk(clk), .reset(rst), .start(start_a), .pattern_sel(sel_a), .frame(frame_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .busy(busy_a), .done(done_a));

  seed_loader #(.SYNC_TO_FRAME(1'b0), .LFSR_SEED(16'hACE1)) dut_b (
    .clk(clk), .reset(rst), .start(start_b), .pattern_sel(sel_b), .frame(frame_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .busy(busy_b), .done(done_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Reference: a Fibonacci LFSR with taps 16,14,13,11 (mask B400) shifting left.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & 16'hB400)};
  endfunction

  // Expected writes of one load: four words then a done pulse, at cycle c0 onward.
  task automatic push_load(input bit to_b, input int c0, input int p);
    item_t it;
    for (int i = 0; i < 4; i++) begin
      it.cyc = c0 + i; it.is_done = 1'b0; it.addr = 2'(i);
      case (p)
        0: it.data = 16'h0000;
        1: it.data = (i == 0) ? 16'h0742 : 16'h0000;
        2: it.data = 16'h0070;
        default: begin
          if (to_b) begin it.data = lfsr_b; lfsr_b = lfsr_next(lfsr_b); end
          else      begin it.data = lfsr_a; lfsr_a = lfsr_next(lfsr_a); end
        end
      endcase
      if (to_b) qb.push_back(it); else qa.push_back(it);
    end
    it.cyc = c0 + 4; it.is_done = 1'b1; it.addr = 2'd0; it.data = 16'h0000;
    if (to_b) qb.push_back(it); else qa.push_back(it);
  endtask

  // Monitor for the frame-synchronised instance.
  always @(negedge clk) begin
    item_t it;
    if (!rst) begin
      if (wr_en_a || done_a) begin
        chk("A_expected_event", qa.size() > 0, 1);
        if (qa.size() > 0) begin
          it = qa.pop_front();
          $display("A cyc=%0d wr_en=%0d done=%0d addr=%0d data=%04h", cyc, wr_en_a, done_a, wr_addr_a, wr_data_a);
          chk("A_cycle", cyc, it.cyc);
          chk("A_kind", {wr_en_a, done_a}, it.is_done ? 2'b01 : 2'b10);
          chk("A_addr_data", {wr_addr_a, wr_data_a}, {it.addr, it.data});
          chk("A_busy", busy_a, !it.is_done);
        end
      end else begin
        chk("A_idle_addr_data", {wr_addr_a, wr_data_a}, 18'h0);
      end
    end
  end

  // Monitor for the immediate instance.
  always @(negedge clk) begin
    item_t it;
    if (!rst) begin
      if (wr_en_b || done_b) begin
        chk("B_expected_event", qb.size() > 0, 1);
        if (qb.size() > 0) begin
          it = qb.pop_front();
          $display("B cyc=%0d wr_en=%0d done=%0d addr=%0d data=%04h", cyc, wr_en_b, done_b, wr_addr_b, wr_data_b);
          chk("B_cycle", cyc, it.cyc);
          chk("B_kind", {wr_en_b, done_b}, it.is_done ? 2'b01 : 2'b10);
          chk("B_addr_data", {wr_addr_b, wr_data_b}, {it.addr, it.data});
          chk("B_busy", busy_b, !it.is_done);
        end
      end else begin
        chk("B_idle_addr_data", {wr_addr_b, wr_data_b}, 18'h0);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One load on the synchronised instance. delay = idle cycles in WAIT_FRAME
  // before the frame pulse; coincident puts a frame pulse on the start cycle;
  // restart re-asserts start with a different pattern while waiting.
  task automatic load_a(input int p, input int delay, input bit coincident, input bit restart);
    start_a = 1'b1; sel_a = 2'(p); frame_a = coincident;
    tick;
    start_a = 1'b0; frame_a = 1'b0;
    chk("A_busy_after_start", busy_a, 1);
    if (restart) begin
      start_a = 1'b1; sel_a = 2'(p ^ 1);
    end
    repeat (delay) tick;
    start_a = 1'b0; sel_a = 2'($urandom_range(0, 3));
    chk("A_waiting_no_write", wr_en_a, 0);
    frame_a = 1'b1;
    push_load(1'b0, cyc + 1, p);
    tick;
    frame_a = 1'b0;
    repeat (6) tick;
    chk("A_busy_after_load", busy_a, 0);
    chk("A_queue_drained", qa.size(), 0);
  endtask

  task automatic load_b(input int p);
    start_b = 1'b1; sel_b = 2'(p);
    push_load(1'b1, cyc + 1, p);
    tick;
    start_b = 1'b0; sel_b = 2'($urandom_range(0, 3));
    repeat (6) tick;
    chk("B_queue_drained", qb.size(), 0);
  endtask

  initial begin
    rst = 1'b0;
    start_a = 1'b0; frame_a = 1'b0; sel_a = 2'd0;
    start_b = 1'b0; frame_b = 1'b0; sel_b = 2'd0;
    #1 rst = 1'b1;
    #1;
    chk("reset_outputs_A", {wr_en_a, wr_addr_a, wr_data_a, busy_a, done_a}, 21'h0);
    chk("reset_outputs_B", {wr_en_b, wr_addr_b, wr_data_b, busy_b, done_b}, 21'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Pattern 3 straight after reset, then a second load continuing the sequence.
    load_a(3, 2, 1'b0, 1'b0);
    load_a(3, 1, 1'b0, 1'b0);
    // Glider with frame five cycles after start.
    load_a(1, 4, 1'b0, 1'b0);
    // Start re-asserted with a different pattern while waiting for frame.
    load_a(1, 3, 1'b0, 1'b1);
    // Frame coincident with start acceptance must not count.
    load_a(2, 4, 1'b1, 1'b0);

    // Abort a pattern-3 load after the addr 1 write.
    start_a = 1'b1; sel_a = 2'd3;
    tick;
    start_a = 1'b0;
    tick;
    frame_a = 1'b1;
    push_load(1'b0, cyc + 1, 3);
    tick;
    frame_a = 1'b0;
    tick;
    #2 rst = 1'b1;
    #1;
    chk("abort_async_outputs", {wr_en_a, wr_addr_a, wr_data_a, busy_a, done_a}, 21'h0);
    qa.delete();
    lfsr_a = 16'hACE1;
    lfsr_b = 16'hACE1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (5) tick;
    load_a(3, 2, 1'b0, 1'b0);

    // Randomised loads on the synchronised instance.
    for (int n = 0; n < 20; n++) begin
      load_a(int'($urandom_range(0, 3)), int'($urandom_range(1, 5)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Immediate instance: blinkers, then start held high for three loads.
    load_b(2);
    start_b = 1'b1; sel_b = 2'd2;
    push_load(1'b1, cyc + 1, 2);
    push_load(1'b1, cyc + 7, 2);
    push_load(1'b1, cyc + 13, 2);
    repeat (17) tick;
    start_b = 1'b0;
    repeat (3) tick;
    chk("B_held_start_drained", qb.size(), 0);
    for (int n = 0; n < 8; n++) load_b(int'($urandom_range(0, 3)));

    chk("final_queue_A", qa.size(), 0);
    chk("final_queue_B", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
